// File: rtl/hazard_sched_if.sv
// Hazard scheduler bus: ID/EX/WB observation inputs and pipeline control outputs.
// HAZ_PERF_CNT_EN adds the stall/flush performance counter outputs.
interface hazard_sched_if;
   logic        mem_stall;
   logic        id_valid;
   logic [6:0]  id_opcode;
   logic [2:0]  id_funct3;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        ex_valid;
   logic [6:0]  ex_opcode;
   logic [4:0]  ex_rd;
   logic        ex_regwe;
   logic        ex_br_taken;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        wb_regwe;
   logic        stall_if;
   logic        stall_id;
   logic        stall_ex;
   logic        bubble_ex;
   logic        flush_id;
   logic [1:0]  pc_sel;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   // Pipeline side: drives the observed stage state, receives control.
   modport master (
      output mem_stall, id_valid, id_opcode, id_funct3, id_rs1, id_rs2,
      output ex_valid, ex_opcode, ex_rd, ex_regwe, ex_br_taken,
      output wb_valid, wb_rd, wb_regwe,
      input  stall_if, stall_id, stall_ex, bubble_ex, flush_id,
      input  pc_sel, fwd_a, fwd_b
`ifdef HAZ_PERF_CNT_EN
      , input perf_stall_cnt, perf_flush_cnt
`endif
   );

   // Scheduler side.
   modport slave (
      input  mem_stall, id_valid, id_opcode, id_funct3, id_rs1, id_rs2,
      input  ex_valid, ex_opcode, ex_rd, ex_regwe, ex_br_taken,
      input  wb_valid, wb_rd, wb_regwe,
      output stall_if, stall_id, stall_ex, bubble_ex, flush_id,
      output pc_sel, fwd_a, fwd_b
`ifdef HAZ_PERF_CNT_EN
      , output perf_stall_cnt, perf_flush_cnt
`endif
   );
endinterface

// File: rtl/hazard_sched.sv
// RV32I pipeline hazard scheduler: stalls, bubbles, flushes, PC select and
// operand forwarding for a 3-stage (ID/EX/WB) pipeline. Control outputs are
// combinational decisions for the current cycle.
// Optional: define HAZ_PERF_CNT_EN for stall/flush performance counters.
module hazard_sched #(
   parameter int unsigned CSR_DRAIN_CYCLES = 2
) (
   input logic           clk,
   input logic           reset,
   hazard_sched_if.slave bus
);
   localparam int unsigned CNT_W = 4;

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
   localparam logic [6:0] OPC_CSR       = 7'b1110011;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_DRAIN    = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
   logic             drained_q, drained_d;
   logic             redirect_pend_q, redirect_pend_d;

   logic       rs1_used, rs2_used;
   logic       hit_ex_rs1, hit_ex_rs2, hit_wb_rs1, hit_wb_rs2;
   logic       load_use;
   logic [1:0] fwd_a_d, fwd_b_d;
   logic       s_if, s_id, s_ex, bub, flush;
   logic [1:0] pc_sel_d;
   logic       run_rules;
   logic       unused_funct3;

   assign unused_funct3 = ^bus.id_funct3[1:0];

   // Register read-port usage of the ID instruction.
   assign rs1_used = !((bus.id_opcode == OPC_LUI) || (bus.id_opcode == OPC_AUIPC) ||
                       (bus.id_opcode == OPC_JAL) ||
                       ((bus.id_opcode == OPC_CSR) && bus.id_funct3[2]));
   assign rs2_used = (bus.id_opcode == OPC_BRANCH) || (bus.id_opcode == OPC_STORE) ||
                     (bus.id_opcode == OPC_ARI_RTYPE);

   assign hit_ex_rs1 = bus.ex_valid && bus.ex_regwe && (bus.ex_rd != 5'd0) &&
                       (bus.ex_rd == bus.id_rs1) && rs1_used;
   assign hit_ex_rs2 = bus.ex_valid && bus.ex_regwe && (bus.ex_rd != 5'd0) &&
                       (bus.ex_rd == bus.id_rs2) && rs2_used;
   assign hit_wb_rs1 = bus.wb_valid && bus.wb_regwe && (bus.wb_rd != 5'd0) &&
                       (bus.wb_rd == bus.id_rs1) && rs1_used;
   assign hit_wb_rs2 = bus.wb_valid && bus.wb_regwe && (bus.wb_rd != 5'd0) &&
                       (bus.wb_rd == bus.id_rs2) && rs2_used;

   assign load_use = (bus.ex_opcode == OPC_LOAD) && (hit_ex_rs1 || hit_ex_rs2);

   // Operand forwarding; a load in EX has no result yet so it never forwards.
   always_comb begin
      fwd_a_d = 2'd0;
      fwd_b_d = 2'd0;
      if (hit_ex_rs1 && (bus.ex_opcode != OPC_LOAD)) fwd_a_d = 2'd1;
      else if (hit_wb_rs1)                           fwd_a_d = 2'd2;
      if (hit_ex_rs2 && (bus.ex_opcode != OPC_LOAD)) fwd_b_d = 2'd1;
      else if (hit_wb_rs2)                           fwd_b_d = 2'd2;
   end

   // Next-state and control decision.
   always_comb begin
      state_d         = state_q;
      drain_cnt_d     = drain_cnt_q;
      drained_d       = drained_q;
      redirect_pend_d = redirect_pend_q;
      s_if            = 1'b0;
      s_id            = 1'b0;
      s_ex            = 1'b0;
      bub             = 1'b0;
      flush           = 1'b0;
      pc_sel_d        = 2'd0;
      run_rules       = 1'b0;

      case (state_q)
         ST_RUN: run_rules = 1'b1;
         ST_DRAIN: begin
            if (bus.mem_stall) begin
               s_if = 1'b1;
               s_id = 1'b1;
               s_ex = 1'b1;
               bub  = 1'b1;
               // A redirect under a memory stall kills the CSR; replay it after the stall.
               if (bus.ex_br_taken) begin
                  redirect_pend_d = 1'b1;
                  drained_d       = 1'b0;
                  state_d         = ST_MEM_WAIT;
               end
            end else if (bus.ex_br_taken) begin
               pc_sel_d = 2'd2;
               flush    = 1'b1;
               bub      = 1'b1;
               state_d  = ST_RUN;
            end else begin
               s_if = 1'b1;
               s_id = 1'b1;
               bub  = 1'b1;
               if (drain_cnt_q == '0) begin
                  drained_d = 1'b1;
                  state_d   = ST_RUN;
               end else begin
                  drain_cnt_d = drain_cnt_q - CNT_W'(1);
               end
            end
         end
         ST_MEM_WAIT: begin
            if (bus.mem_stall) begin
               s_if = 1'b1;
               s_id = 1'b1;
               s_ex = 1'b1;
               if (bus.ex_br_taken) redirect_pend_d = 1'b1;
            end else begin
               state_d = ST_RUN;
               if (redirect_pend_q) begin
                  pc_sel_d        = 2'd2;
                  flush           = 1'b1;
                  bub             = 1'b1;
                  redirect_pend_d = 1'b0;
               end else begin
                  run_rules = 1'b1;
               end
            end
         end
         default: state_d = ST_RUN;
      endcase

      if (run_rules) begin
         if (bus.mem_stall) begin
            s_if    = 1'b1;
            s_id    = 1'b1;
            s_ex    = 1'b1;
            state_d = ST_MEM_WAIT;
            if (bus.ex_br_taken) redirect_pend_d = 1'b1;
         end else if (bus.ex_br_taken) begin
            pc_sel_d = 2'd2;
            flush    = 1'b1;
            bub      = 1'b1;
         end else if (load_use) begin
            s_if = 1'b1;
            s_id = 1'b1;
            bub  = 1'b1;
         end else if (bus.id_valid && (bus.id_opcode == OPC_CSR) && !drained_q) begin
            s_if        = 1'b1;
            s_id        = 1'b1;
            bub         = 1'b1;
            drain_cnt_d = CNT_W'(CSR_DRAIN_CYCLES - 1);
            state_d     = ST_DRAIN;
         end else if (bus.id_valid && (bus.id_opcode == OPC_JAL)) begin
            pc_sel_d = 2'd1;
            flush    = 1'b1;
         end
      end

      // The drained credit belongs to the instruction in ID; it expires when ID moves.
      if (!s_id) drained_d = 1'b0;
   end

   // Control outputs are held at zero during reset.
   assign bus.stall_if  = s_if  && !reset;
   assign bus.stall_id  = s_id  && !reset;
   assign bus.stall_ex  = s_ex  && !reset;
   assign bus.bubble_ex = bub   && !reset;
   assign bus.flush_id  = flush && !reset;
   assign bus.pc_sel    = reset ? 2'd0 : pc_sel_d;
   assign bus.fwd_a     = reset ? 2'd0 : fwd_a_d;
   assign bus.fwd_b     = reset ? 2'd0 : fwd_b_d;

   // FSM state and drain bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_RUN;
         drain_cnt_q     <= '0;
         drained_q       <= 1'b0;
         redirect_pend_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         drain_cnt_q     <= drain_cnt_d;
         drained_q       <= drained_d;
         redirect_pend_q <= redirect_pend_d;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] perf_stall_cnt_q, perf_flush_cnt_q;

   // Free-running stall/flush event counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_cnt_q <= '0;
         perf_flush_cnt_q <= '0;
      end else begin
         if (s_id)  perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
         if (flush) perf_flush_cnt_q <= perf_flush_cnt_q + 32'd1;
      end
   end

   assign bus.perf_stall_cnt = perf_stall_cnt_q;
   assign bus.perf_flush_cnt = perf_flush_cnt_q;
`endif
endmodule
